// File: rtl/pio_edge_irq_if.sv
// Avalon-MM slave bus bundle for the PIO edge/IRQ block.
// Latency: pure wiring, no storage.
// Backpressure: none; the slave never inserts wait states.
//
// Signals:
//   address    - word address (0..7)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - 32-bit write data
//   readdata   - 32-bit registered read data (driven by the slave)
interface pio_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_edge_irq.sv
// Parallel I/O port with synchronised inputs, per-bit edge capture and a maskable interrupt.
// Latency: reads 1 cycle; input -> data_in 2 edges, -> edge_capture/edge irq 3 edges.
// Backpressure: none; every write is accepted on the clock it is presented.
//
// Ports:
//   clk       - sole clock, rising edge
//   reset_n   - asynchronous active-low reset
//   bus       - Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port   - asynchronous external inputs
//   out_port  - registered output data
//   irq       - active-high interrupt request
//
// Register map (word addresses):
//   0 data        R: synchronised inputs   W: out_port <= writedata
//   1 reserved    R: 0                     W: ignored
//   2 irq_mask    RW
//   3 edge_capture R                       W: write-1-to-clear per bit
//   4 outset      R: 0                     W: out_port <= out_port | writedata
//   5 outclear    R: 0                     W: out_port <= out_port & ~writedata
//   6,7 reserved  R: 0                     W: ignored
module pio_edge_irq #(
    parameter int WIDTH     = 8,   // 1..32
    parameter int EDGE_TYPE = 0,   // 0 rising, 1 falling, 2 any
    parameter int IRQ_TYPE  = 1    // 0 level, 1 edge
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_edge_irq_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;          // first metastability stage
    logic [WIDTH-1:0] sync2_q;          // data_in as seen by software
    logic [WIDTH-1:0] prev_q;           // sync2 delayed one cycle, for edges
    logic [WIDTH-1:0] out_port_q,     out_port_d;
    logic [WIDTH-1:0] irq_mask_q,     irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]      readdata_q,     readdata_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];

    // Bits above WIDTH-1 carry no meaning; fold them so they are consumed.
    assign unused_wdata = ^{1'b0, bus.writedata};

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    logic [WIDTH-1:0] edge_det;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det =  sync2_q & ~prev_q;
            1:       edge_det = ~sync2_q &  prev_q;
            default: edge_det =  sync2_q ^  prev_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Register next-state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cap_clr;

    always_comb begin
        out_port_d = out_port_q;
        irq_mask_d = irq_mask_q;
        cap_clr    = '0;

        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     out_port_d = wdata;
                ADDR_IRQ_MASK: irq_mask_d = wdata;
                ADDR_EDGE_CAP: cap_clr    = wdata;
                ADDR_OUTSET:   out_port_d = out_port_q | wdata;
                ADDR_OUTCLR:   out_port_d = out_port_q & ~wdata;
                default:       ;
            endcase
        end

        // A fresh edge in the same cycle as a clear keeps the bit set, so an
        // event arriving while software acknowledges the previous one is not lost.
        edge_capture_d = (edge_capture_q & ~cap_clr) | edge_det;
    end

    // ------------------------------------------------------------------
    // Read mux: sampled every cycle regardless of chipselect
    // ------------------------------------------------------------------
    logic [31:0] data_in_ext;
    logic [31:0] irq_mask_ext;
    logic [31:0] edge_cap_ext;

    always_comb begin
        data_in_ext                = '0;
        irq_mask_ext               = '0;
        edge_cap_ext               = '0;
        data_in_ext[WIDTH-1:0]     = sync2_q;
        irq_mask_ext[WIDTH-1:0]    = irq_mask_q;
        edge_cap_ext[WIDTH-1:0]    = edge_capture_q;

        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:     readdata_d = data_in_ext;
            ADDR_IRQ_MASK: readdata_d = irq_mask_ext;
            ADDR_EDGE_CAP: readdata_d = edge_cap_ext;
            default:       readdata_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port_q     <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            out_port_q     <= out_port_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_port     = out_port_q;
    assign bus.readdata = readdata_q;

    // Decoded straight from flops so reset clears it without a clock.
    always_comb begin
        if (IRQ_TYPE == 0) begin
            irq = |(sync2_q & irq_mask_q);
        end else begin
            irq = |(edge_capture_q & irq_mask_q);
        end
    end

endmodule

// File: tb/tb_pio_edge_irq.sv
// Bench for pio_edge_irq: three instances share one bus-driving stream
// (u0: rising/edge irq, u1: rising/level irq, u2: any-edge/edge irq).
// Expected read and output values go through a scoreboard queue.
module tb_pio_edge_irq;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    logic [7:0]  in_port0, in_port1, in_port2;
    logic [7:0]  out_port0, out_port1, out_port2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pio_edge_irq_if bus0();
    pio_edge_irq_if bus1();
    pio_edge_irq_if bus2();

    assign bus0.address = address;    assign bus1.address = address;    assign bus2.address = address;
    assign bus0.chipselect = chipselect; assign bus1.chipselect = chipselect; assign bus2.chipselect = chipselect;
    assign bus0.write_n = write_n;    assign bus1.write_n = write_n;    assign bus2.write_n = write_n;
    assign bus0.writedata = writedata; assign bus1.writedata = writedata; assign bus2.writedata = writedata;

    pio_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .in_port(in_port0), .out_port(out_port0), .irq(irq0));
    pio_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(0)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .in_port(in_port1), .out_port(out_port1), .irq(irq1));
    pio_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(1)) u2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .in_port(in_port2), .out_port(out_port2), .irq(irq2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    function automatic logic [31:0] rd_of(input int idx);
        case (idx)
            0:       return bus0.readdata;
            1:       return bus1.readdata;
            default: return bus2.readdata;
        endcase
    endfunction

    task automatic do_read(input int idx, input logic [2:0] a, output logic [31:0] got);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        got        = rd_of(idx);
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_port0 !== 8'h00) begin errors++; $display("FAIL reset_out_port: got %h exp 00", out_port0); end
        checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h exp 0", bus0.readdata); end
        checks++; if ({irq0, irq1, irq2} !== 3'b000) begin errors++; $display("FAIL reset_irq: got %b exp 000", {irq0, irq1, irq2}); end
    endtask

    task automatic test_first_write();
        logic [31:0] e;
        reset_n = 1'b1;
        exp_q.push_back(32'h5A);
        do_write(3'd0, 32'hFFFF_FF5A);
        e = exp_q.pop_front();
        checks++; if ({24'h0, out_port0} !== e) begin errors++; $display("FAIL first_write: got %h exp %h", out_port0, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic [2:0]  addrs [3] = '{3'd0, 3'd4, 3'd5};
        logic [31:0] datas [3] = '{32'hA5, 32'h0F, 32'h81};
        logic [31:0] exps  [3] = '{32'hA5, 32'hAF, 32'h2E};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            do_write(addrs[i], datas[i]);
            e = exp_q.pop_front();
            checks++; if ({24'h0, out_port0} !== e) begin errors++; $display("FAIL b2b_out_port[%0d]: got %h exp %h", i, out_port0, e); end
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] got, e;
        do_write(3'd3, 32'hFF);
        do_write(3'd2, 32'h01);
        in_port0 = 8'h01;
        tick();
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL edge_irq_e1: got %b exp 0", irq0); end
        tick();
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL edge_irq_e2: got %b exp 0", irq0); end
        tick();
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL edge_irq_e3: got %b exp 1", irq0); end
        exp_q.push_back(32'h01);
        do_read(0, 3'd3, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL edge_cap_read: got %h exp %h", got, e); end
        do_write(3'd3, 32'h01);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL edge_irq_clear: got %b exp 0", irq0); end
    endtask

    task automatic test_set_wins();
        logic [31:0] got, e;
        in_port0 = 8'h05;
        tick();
        tick();
        do_write(3'd3, 32'h04);   // lands on the edge-detect cycle of bit 2
        exp_q.push_back(32'h04);
        do_read(0, 3'd3, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL set_wins: got %h exp %h", got, e); end
        do_write(3'd3, 32'h04);
        exp_q.push_back(32'h00);
        do_read(0, 3'd3, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL plain_clear: got %h exp %h", got, e); end
    endtask

    task automatic test_level_irq();
        logic [31:0] got, e;
        do_write(3'd2, 32'h80);
        in_port1 = 8'h80;
        tick();
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL level_irq_e1: got %b exp 0", irq1); end
        tick();
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL level_irq_e2: got %b exp 1", irq1); end
        exp_q.push_back(32'h80);
        do_read(1, 3'd0, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL data_in_read: got %h exp %h", got, e); end
        do_write(3'd2, 32'h00);
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL level_irq_masked: got %b exp 0", irq1); end
        in_port1 = 8'h00;
        tick(); tick(); tick();
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL level_irq_stays_low: got %b exp 0", irq1); end
    endtask

    task automatic test_any_edge();
        logic [31:0] got, e;
        do_write(3'd3, 32'hFF);
        do_write(3'd2, 32'h08);
        in_port2 = 8'h08;
        tick();
        tick();
        checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_rise_early: got %b exp 0", irq2); end
        tick();
        checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_rise: got %b exp 1", irq2); end
        do_write(3'd3, 32'h08);
        checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_clear: got %b exp 0", irq2); end
        in_port2 = 8'h00;
        tick();
        tick();
        checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_fall_early: got %b exp 0", irq2); end
        tick();
        checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_fall: got %b exp 1", irq2); end
        exp_q.push_back(32'h08);
        do_read(2, 3'd3, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL any_fall_read: got %h exp %h", got, e); end
    endtask

    task automatic test_isolation();
        logic [31:0] got, e;
        do_write(3'd2, 32'h3C);
        do_write(3'd0, 32'hFF);
        do_write(3'd4, 32'h00);
        do_write(3'd5, 32'hF0);
        do_write(3'd1, 32'h77);
        do_write(3'd6, 32'h55);
        do_write(3'd7, 32'hAA);
        checks++; if (out_port0 !== 8'h0F) begin errors++; $display("FAIL iso_out_port: got %h exp 0f", out_port0); end
        checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL iso_irq2: got %b exp 1", irq2); end
        exp_q.push_back(32'h3C);
        do_read(2, 3'd2, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL iso_mask_read: got %h exp %h", got, e); end
        exp_q.push_back(32'h08);
        do_read(2, 3'd3, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL iso_cap_read: got %h exp %h", got, e); end
        exp_q.push_back(32'h05);
        do_read(0, 3'd0, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL iso_data_read: got %h exp %h", got, e); end
        for (int a = 4; a < 8; a++) begin
            exp_q.push_back(32'h0);
            do_read(0, 3'(a), got);
            e = exp_q.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL reserved_read[%0d]: got %h exp %h", a, got, e); end
        end
        exp_q.push_back(32'h0);
        do_read(0, 3'd1, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL reserved_read[1]: got %h exp %h", got, e); end
        do_write(3'd3, 32'hFF);
        checks++; if (out_port0 !== 8'h0F) begin errors++; $display("FAIL iso_cap_write_out: got %h exp 0f", out_port0); end
        checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL iso_cap_write_irq: got %b exp 0", irq2); end
    endtask

    task automatic test_async_reset();
        logic [31:0] got, e;
        do_write(3'd3, 32'hFF);
        do_write(3'd2, 32'h01);
        do_write(3'd0, 32'h5A);
        in_port0 = 8'h00;
        tick(); tick(); tick();
        in_port0 = 8'h01;
        tick(); tick(); tick();
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b exp 1", irq0); end
        in_port0   = 8'h03;       // bit 1 edge still in the synchroniser
        address    = 3'd3;
        chipselect = 1'b0;        // readdata follows address regardless
        exp_q.push_back(32'h01);
        tick();
        got = bus0.readdata;
        e   = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL pre_reset_readdata: got %h exp %h", got, e); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL async_irq: got %b exp 0", irq0); end
        checks++; if (out_port0 !== 8'h00) begin errors++; $display("FAIL async_out_port: got %h exp 00", out_port0); end
        checks++; if (bus0.readdata !== 32'h0) begin errors++; $display("FAIL async_readdata: got %h exp 0", bus0.readdata); end
        tick(); tick();
        reset_n = 1'b1;
        do_write(3'd2, 32'h01);
        tick();
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL post_reset_early: got %b exp 0", irq0); end
        tick();
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL post_reset_rise: got %b exp 1", irq0); end
        exp_q.push_back(32'h03);
        do_read(0, 3'd3, got);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL post_reset_cap: got %h exp %h", got, e); end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port0   = 8'h00;
        in_port1   = 8'h00;
        in_port2   = 8'h00;
        tick();
        tick();
        test_reset();
        test_first_write();
        test_back_to_back();
        test_edge_irq();
        test_set_wins();
        test_level_irq();
        test_any_edge();
        test_isolation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
